// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory-side blocks.
// Holds the data-memory arbiter FSM state/id encodings and widths.
package mips_pkg;

   localparam int unsigned DATA_MEM_WIDTH = 32;
   localparam int unsigned ARB_LAT_WIDTH  = 3;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESP
   } arb_state_e;

   typedef enum logic {
      ARB_CORE,
      ARB_DMA
   } arb_id_e;

endpackage

// File: rtl/mips_dmem_arbiter_if.sv
// One requester's request/response channel into the data-memory arbiter.
// master : requester side (drives req_valid/we/addr/wdata)
// slave  : arbiter side (drives req_ready and the resp_* pulse)
interface mips_dmem_arbiter_if
   import mips_pkg::*;
#(
   parameter int unsigned DW = DATA_MEM_WIDTH
) ();

   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [DW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/mips_rr_arbiter2.sv
// Combinational two-way round-robin grant.
// req[1:0]   : request vector (bit 0 = core, bit 1 = dma)
// last_grant : requester granted most recently; loses a tie
// gnt_c[1:0] : one-hot grant, zero when nobody requests
module mips_rr_arbiter2
   import mips_pkg::*;
(
   input  logic [1:0] req,
   input  arb_id_e    last_grant,
   output logic [1:0] gnt_c
);

   always_comb begin : grant
      gnt_c = 2'b00;
      case (req)
         2'b01:   gnt_c = 2'b01;
         2'b10:   gnt_c = 2'b10;
         2'b11:   gnt_c = (last_grant == ARB_DMA) ? 2'b01 : 2'b10;
         default: gnt_c = 2'b00;
      endcase
   end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Shares the single-port data memory between the core data port and a
// DMA/debug port. One transaction at a time, fixed-latency memory, one
// response per accepted request; out-of-range addresses answer with err.
// clk, rst          : clock, synchronous active-high reset
// core, dma         : requester channels (slave side)
// mem_en/we/addr/wdata, mem_rdata : data memory macro
// busy              : transaction in flight
module mips_dmem_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned   DW          = DATA_MEM_WIDTH,
   parameter int unsigned   MEM_LATENCY = 1,
   parameter logic [DW-1:0] ADDR_LIMIT  = DW'(32'h0000_0400)
) (
   input  logic                 clk,
   input  logic                 rst,
   mips_dmem_arbiter_if.slave   core,
   mips_dmem_arbiter_if.slave   dma,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [DW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata,
   output logic                 busy
);

   arb_state_e               state_q, state_d;
   arb_id_e                  id_q, id_d;
   arb_id_e                  last_q, last_d;
   logic                     we_q, we_d;
   logic [DW-1:0]            addr_q, addr_d;
   logic [DW-1:0]            wdata_q, wdata_d;
   logic [ARB_LAT_WIDTH-1:0] cnt_q, cnt_d;

   logic          mem_en_d, busy_d;
   logic          core_rv_d, core_err_d, dma_rv_d, dma_err_d;
   logic [DW-1:0] core_rd_d, dma_rd_d;

   logic [1:0]    req_c, gnt_c;
   logic          core_ready_c, dma_ready_c;
   arb_id_e       sel_id_c;
   logic          sel_we_c;
   logic [DW-1:0] sel_addr_c, sel_wdata_c;

   assign req_c = {dma.req_valid, core.req_valid};

   mips_rr_arbiter2 u_rr (
      .req        (req_c),
      .last_grant (last_q),
      .gnt_c      (gnt_c)
   );

   // Payload of whichever requester currently holds the grant
   assign sel_id_c    = gnt_c[1] ? ARB_DMA       : ARB_CORE;
   assign sel_we_c    = gnt_c[1] ? dma.req_we    : core.req_we;
   assign sel_addr_c  = gnt_c[1] ? dma.req_addr  : core.req_addr;
   assign sel_wdata_c = gnt_c[1] ? dma.req_wdata : core.req_wdata;

   assign core.req_ready = core_ready_c;
   assign dma.req_ready  = dma_ready_c;

   // Memory command fields come straight from the captured request
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // Next-state and registered-output decode
   always_comb begin : next_state
      state_d      = state_q;
      id_d         = id_q;
      last_d       = last_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      mem_en_d     = 1'b0;
      core_rv_d    = 1'b0;
      core_rd_d    = '0;
      core_err_d   = 1'b0;
      dma_rv_d     = 1'b0;
      dma_rd_d     = '0;
      dma_err_d    = 1'b0;
      core_ready_c = 1'b0;
      dma_ready_c  = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            core_ready_c = gnt_c[0];
            dma_ready_c  = gnt_c[1];
            if (gnt_c != 2'b00) begin
               id_d    = sel_id_c;
               last_d  = sel_id_c;
               we_d    = sel_we_c;
               addr_d  = sel_addr_c;
               wdata_d = sel_wdata_c;
               if (sel_addr_c < ADDR_LIMIT) begin
                  state_d  = ARB_ISSUE;
                  mem_en_d = 1'b1;
               end else begin
                  // Out of range: answer next cycle, never touch memory
                  state_d    = ARB_RESP;
                  core_rv_d  = (sel_id_c == ARB_CORE);
                  core_err_d = (sel_id_c == ARB_CORE);
                  dma_rv_d   = (sel_id_c == ARB_DMA);
                  dma_err_d  = (sel_id_c == ARB_DMA);
               end
            end
         end

         ARB_ISSUE: begin
            cnt_d   = ARB_LAT_WIDTH'(MEM_LATENCY - 1);
            state_d = ARB_WAIT;
         end

         ARB_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ARB_RESP;
               if (id_q == ARB_CORE) begin
                  core_rv_d = 1'b1;
                  core_rd_d = we_q ? '0 : mem_rdata;
               end else begin
                  dma_rv_d = 1'b1;
                  dma_rd_d = we_q ? '0 : mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - ARB_LAT_WIDTH'(1);
            end
         end

         ARB_RESP: state_d = ARB_IDLE;

         default: state_d = ARB_IDLE;
      endcase

      busy_d = (state_d != ARB_IDLE);
   end

   // State, captured request and registered outputs
   always_ff @(posedge clk) begin : regs
      if (rst) begin
         state_q         <= ARB_IDLE;
         id_q            <= ARB_CORE;
         last_q          <= ARB_DMA;
         we_q            <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         cnt_q           <= '0;
         mem_en          <= 1'b0;
         busy            <= 1'b0;
         core.resp_valid <= 1'b0;
         core.resp_rdata <= '0;
         core.resp_err   <= 1'b0;
         dma.resp_valid  <= 1'b0;
         dma.resp_rdata  <= '0;
         dma.resp_err    <= 1'b0;
      end else begin
         state_q         <= state_d;
         id_q            <= id_d;
         last_q          <= last_d;
         we_q            <= we_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         cnt_q           <= cnt_d;
         mem_en          <= mem_en_d;
         busy            <= busy_d;
         core.resp_valid <= core_rv_d;
         core.resp_rdata <= core_rd_d;
         core.resp_err   <= core_err_d;
         dma.resp_valid  <= dma_rv_d;
         dma.resp_rdata  <= dma_rd_d;
         dma.resp_err    <= dma_err_d;
      end
   end

endmodule
